uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
Second-generation UART receiver for the servo UART IP. It adds runtime-configurable framing: 5–9 data bits, none/even/odd/mark/space parity, and 1 or 2 stop bits. Each bit is decided by 3-sample majority vote, and the block detects framing errors, parity errors and line breaks. Received words, each with per-word status, go into an internal first-word-fall-through FIFO read over a valid/ready interface by the register/bus block.

Parameters:
BAUD_W, 16, width of baud_divisor and bit counter
FIFO_DEPTH, 16, entries in receive FIFO; power of 2, >= 2
LEVEL_W, 5, width of fifo_level; equals log2(FIFO_DEPTH)+1

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
rx_en  input  1  receiver enable; 0 forces IDLE at the next frame boundary
baud_divisor  input  BAUD_W  clocks per bit N; legal N >= 4
cfg_data_bits  input  3  data bits: 5..9; any other value means 8
cfg_parity  input  3  parity mode: 0 none, 1 even, 2 odd, 3 mark, 4 space; others mean none
cfg_stop  input  1  stop bits: 0 one, 1 two
rx  input  1  asynchronous serial input, idle high
m_data  output  12  {brk, ferr, perr, data[8:0]}; data right-justified, unused MSBs 0
m_valid  output  1  FIFO not empty
m_ready  input  1  consumer accepts head word when m_valid&m_ready
fifo_level  output  LEVEL_W  number of words in FIFO
ovf  output  1  sticky overflow flag
clr_ovf  input  1  synchronous clear of ovf
rx_busy  output  1  state != IDLE

Behaviour:
- Reset (reset_n=0, async): FSM to IDLE; counters clear; FIFO empty; m_valid=0, m_data=0, fifo_level=0, ovf=0, rx_busy=0. Both rx synchroniser flops reset to 1, so no false start is seen after reset. Reset mid-frame discards the partial word.
- Sync: 2-flop synchroniser gives rxs; rxs_d is rxs delayed one cycle. Start edge = rxs_d & ~rxs.
- Config latch: on the start edge in IDLE (with rx_en=1), latch N, data bit count D, parity mode and stop count. Mid-frame config changes have no effect.
- Bit timing: counter s runs 0..N-1 per bit; s=0 on the cycle after the start edge; h = N>>1. Bit value = majority of rxs at s = h-1, h, h+1; the decision is made at s = h+1. At s = N-1, s wraps to 0 and the next bit begins.
- FSM states:
  - IDLE: on start edge & rx_en, go to START.
  - START: at the decision, majority 1 means a glitch: go to IDLE, nothing pushed. Otherwise continue to DATA at the bit wrap.
  - DATA: shift LSB first; after D bits go to PARITY if parity mode != none, else STOP.
  - PARITY: sample parity bit p; then STOP.
  - STOP: at the first stop bit's decision, go to IDLE if cfg_stop=0; else continue to STOP2 at the bit wrap.
  - STOP2: at its decision, go to IDLE.
  - BRK_WAIT: stay until rxs=1, then go to IDLE.
- Parity check: even requires ^data ^ p = 0; odd requires 1; mark requires p = 1; space requires p = 0. perr = 1 on mismatch; perr = 0 when parity mode is none.
- ferr = 1 if any stop bit majority is 0.
- brk = 1 when data = 0, p = 0 (if parity enabled) and the first stop majority is 0. A brk word also has ferr = 1. After pushing it, go to BRK_WAIT instead of IDLE; STOP2 is skipped.
- Push: the word is pushed on the final stop decision cycle and is visible on m_valid/m_data the next cycle. Returning to IDLE at mid-stop lets back-to-back frames be received.
- FIFO: pop on m_valid & m_ready; m_data always shows the head word.
  - Push when full with no pop in the same cycle: the word is dropped and ovf is set.
  - Simultaneous push and pop when full: both succeed, level unchanged, no overflow.
  - Push into empty: m_valid rises the next cycle; the word cannot be popped in the push cycle.
  - fifo_level counts 0..FIFO_DEPTH.
- ovf: set has priority over clr_ovf in the same cycle.
- rx_en=0: no new start is accepted; a frame in progress completes normally.

Test Plan:
- N=16, 8N1, byte 0xA5 -> exactly one word m_data=0x0A5, flags 0; m_valid rises 1 cycle after the stop-bit decision.
- N=16, 7 data bits, even parity, data 0x35 sent with p=1 -> m_data = perr set, data 0x035; same frame with p=0 -> perr=0.
- rx low for 3 clocks only (N=16) -> START rejects the glitch, no push, rx_busy returns to 0, fifo_level=0.
- 9 data bits, 2 stop bits, second stop bit driven 0 -> ferr=1, data correct; the next frame sent back-to-back is received cleanly.
- rx held low for 20 bit times, 8N1 -> one word with brk=1, ferr=1, data 0; no further words until rx goes high, then the next 0x55 frame is received normally.
- FIFO_DEPTH=4, m_ready=0, five frames 0x01..0x05 -> fifo_level=4, ovf=1, words 0x01..0x04 retained; clr_ovf -> ovf=0; push and pop in the same cycle while full -> no ovf.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// UART receiver with runtime framing (5-9 data bits, parity, 1/2 stop), 3-sample majority
// voting, framing/parity/break detection, feeding a first-word-fall-through receive FIFO.
module uart_rx_fifo #(
    parameter int BAUD_W     = 16,
    parameter int FIFO_DEPTH = 16,
    parameter int LEVEL_W    = 5
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               rx_en,
    input  logic [BAUD_W-1:0]  baud_divisor,
    input  logic [2:0]         cfg_data_bits,
    input  logic [2:0]         cfg_parity,
    input  logic               cfg_stop,
    input  logic               rx,
    output logic [11:0]        m_data,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [LEVEL_W-1:0] fifo_level,
    output logic               ovf,
    input  logic               clr_ovf,
    output logic               rx_busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [2:0] PAR_NONE  = 3'd0;
    localparam logic [2:0] PAR_EVEN  = 3'd1;
    localparam logic [2:0] PAR_ODD   = 3'd2;
    localparam logic [2:0] PAR_MARK  = 3'd3;
    localparam logic [2:0] PAR_SPACE = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_STOP2, S_BRK_WAIT
    } state_t;

    logic              r_rx_s1, r_rxs, r_rxs_d;
    state_t            r_state;
    logic [BAUD_W-1:0] r_s, r_n;
    logic [3:0]        r_dbits, r_bitcnt;
    logic [2:0]        r_par;
    logic              r_stop2;
    logic [8:0]        r_shift;
    logic              r_p, r_ferr, r_smp0, r_smp1;

    logic [AW-1:0]      r_wr_ptr, r_rd_ptr;
    logic [LEVEL_W-1:0] r_level;
    logic               r_ovf;
    logic [11:0]        r_mem [FIFO_DEPTH];

    logic              w_start, w_dec, w_wrap, w_maj, w_xor;
    logic              w_brk, w_ferr, w_perr, w_push;
    logic              w_full, w_pop, w_wr;
    logic [BAUD_W-1:0] w_half;
    logic [3:0]        w_cfg_dbits, w_bits_next;
    logic [2:0]        w_cfg_par;
    logic [8:0]        w_data;
    logic [11:0]       w_word;

    // The data-bit count is the 3-bit residue of D: 5,6,7 literal, 1 means 9, the rest 8.
    always_comb begin
        case (cfg_data_bits)
            3'd5:    w_cfg_dbits = 4'd5;
            3'd6:    w_cfg_dbits = 4'd6;
            3'd7:    w_cfg_dbits = 4'd7;
            3'd1:    w_cfg_dbits = 4'd9;
            default: w_cfg_dbits = 4'd8;
        endcase
        w_cfg_par = (cfg_parity <= PAR_SPACE) ? cfg_parity : PAR_NONE;
    end

    assign w_start     = r_rxs_d & ~r_rxs;
    assign w_half      = r_n >> 1;
    assign w_dec       = (r_s == w_half + BAUD_W'(1));
    assign w_wrap      = (r_s == r_n - BAUD_W'(1));
    assign w_maj       = (r_smp0 & r_smp1) | (r_smp0 & r_rxs) | (r_smp1 & r_rxs);
    assign w_bits_next = r_bitcnt + {3'b000, w_dec};

    // Bits enter at the MSB, so the received word sits left-aligned until shifted down.
    assign w_data = r_shift >> (4'd9 - r_dbits);
    assign w_xor  = (^w_data) ^ r_p;

    always_comb begin
        case (r_par)
            PAR_EVEN:  w_perr = w_xor;
            PAR_ODD:   w_perr = ~w_xor;
            PAR_MARK:  w_perr = ~r_p;
            PAR_SPACE: w_perr = r_p;
            default:   w_perr = 1'b0;
        endcase
    end

    assign w_brk  = (r_state == S_STOP) & w_dec & ~w_maj & (w_data == 9'd0) &
                    ((r_par == PAR_NONE) | ~r_p);
    assign w_ferr = ~w_maj | ((r_state == S_STOP2) & r_ferr);
    assign w_push = w_dec & (((r_state == S_STOP) & (w_brk | ~r_stop2)) | (r_state == S_STOP2));
    assign w_word = {w_brk, w_ferr, w_perr, w_data};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_s1 <= 1'b1;
            r_rxs   <= 1'b1;
            r_rxs_d <= 1'b1;
        end else begin
            r_rx_s1 <= rx;
            r_rxs   <= r_rx_s1;
            r_rxs_d <= r_rxs;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_s      <= '0;
            r_n      <= '0;
            r_dbits  <= 4'd8;
            r_bitcnt <= '0;
            r_par    <= PAR_NONE;
            r_stop2  <= 1'b0;
            r_shift  <= '0;
            r_p      <= 1'b0;
            r_ferr   <= 1'b0;
            r_smp0   <= 1'b1;
            r_smp1   <= 1'b1;
        end else begin
            if (r_s == w_half - BAUD_W'(1)) r_smp0 <= r_rxs;
            if (r_s == w_half)              r_smp1 <= r_rxs;
            if (r_state != S_IDLE)
                r_s <= w_wrap ? '0 : r_s + BAUD_W'(1);

            case (r_state)
                S_IDLE: begin
                    if (w_start && rx_en) begin
                        r_state  <= S_START;
                        r_s      <= '0;
                        r_n      <= baud_divisor;
                        r_dbits  <= w_cfg_dbits;
                        r_par    <= w_cfg_par;
                        r_stop2  <= cfg_stop;
                        r_bitcnt <= '0;
                        r_shift  <= '0;
                        r_p      <= 1'b0;
                        r_ferr   <= 1'b0;
                    end
                end
                S_START: begin
                    if (w_dec && w_maj) r_state <= S_IDLE;
                    else if (w_wrap)    r_state <= S_DATA;
                end
                S_DATA: begin
                    if (w_dec) begin
                        r_shift  <= {w_maj, r_shift[8:1]};
                        r_bitcnt <= w_bits_next;
                    end
                    if (w_wrap && w_bits_next == r_dbits)
                        r_state <= (r_par == PAR_NONE) ? S_STOP : S_PARITY;
                end
                S_PARITY: begin
                    if (w_dec)  r_p     <= w_maj;
                    if (w_wrap) r_state <= S_STOP;
                end
                S_STOP: begin
                    if (w_dec) begin
                        r_ferr <= ~w_maj;
                        if (w_brk)         r_state <= S_BRK_WAIT;
                        else if (!r_stop2) r_state <= S_IDLE;
                        else if (w_wrap)   r_state <= S_STOP2;
                    end else if (w_wrap) begin
                        r_state <= S_STOP2;
                    end
                end
                S_STOP2: begin
                    if (w_dec) r_state <= S_IDLE;
                end
                S_BRK_WAIT: begin
                    if (r_rxs) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign rx_busy = (r_state != S_IDLE);

    // A full FIFO still accepts a push when the head is popped on the same edge.
    assign w_full = (r_level == LEVEL_W'(FIFO_DEPTH));
    assign w_pop  = m_valid & m_ready;
    assign w_wr   = w_push & (~w_full | w_pop);

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= w_word;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_wr)  r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_wr, w_pop})
                2'b10:   r_level <= r_level + LEVEL_W'(1);
                2'b01:   r_level <= r_level - LEVEL_W'(1);
                default: r_level <= r_level;
            endcase
            if (w_push && w_full && !w_pop) r_ovf <= 1'b1;
            else if (clr_ovf)               r_ovf <= 1'b0;
        end
    end

    assign m_valid    = (r_level != '0);
    assign m_data     = m_valid ? r_mem[r_rd_ptr] : 12'd0;
    assign fifo_level = r_level;
    assign ovf        = r_ovf;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: framing variants, glitch, break, and FIFO overflow
// with a 4-entry FIFO at 16 clocks per bit.
module tb_uart_rx_fifo;
    localparam int N = 16;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        rx_en;
    logic [15:0] baud_divisor;
    logic [2:0]  cfg_data_bits;
    logic [2:0]  cfg_parity;
    logic        cfg_stop;
    logic        rx;
    logic [11:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic [2:0]  fifo_level;
    logic        ovf;
    logic        clr_ovf;
    logic        rx_busy;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    uart_rx_fifo #(.BAUD_W(16), .FIFO_DEPTH(4), .LEVEL_W(3)) dut (
        .clk(clk), .reset_n(reset_n), .rx_en(rx_en), .baud_divisor(baud_divisor),
        .cfg_data_bits(cfg_data_bits), .cfg_parity(cfg_parity), .cfg_stop(cfg_stop),
        .rx(rx), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .fifo_level(fifo_level), .ovf(ovf), .clr_ovf(clr_ovf), .rx_busy(rx_busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic v);
        rx = v;
        repeat (N) @(posedge clk);
        #1;
    endtask

    // Caller must be at posedge+1; returns at posedge+1 so frames can be chained.
    task automatic send_frame(input logic [8:0] data, input int nbits, input bit has_par,
                              input bit pbit, input bit s1, input bit two_stop,
                              input bit s2, input int idle_bits);
        drive_bit(1'b0);
        for (int i = 0; i < nbits; i++) drive_bit(data[i]);
        if (has_par) drive_bit(pbit);
        drive_bit(s1);
        if (two_stop) drive_bit(s2);
        for (int i = 0; i < idle_bits; i++) drive_bit(1'b1);
    endtask

    task automatic pop_expect(input string tag, input logic [11:0] exp);
        int t = 0;
        @(negedge clk);
        while (!m_valid && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_valid"}, m_valid, 1);
        check(tag, m_data, exp);
        $display("pop %s: m_data=0x%03h", tag, m_data);
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        m_ready = 1'b0;
    endtask

    initial begin
        rx = 1'b1; m_ready = 1'b0; clr_ovf = 1'b0; rx_en = 1'b1;
        baud_divisor = 16'(N); cfg_data_bits = 3'd0; cfg_parity = 3'd0; cfg_stop = 1'b0;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", m_valid, 0);
        check("rst_data", m_data, 0);
        check("rst_level", fifo_level, 0);
        check("rst_ovf", ovf, 0);
        check("rst_busy", rx_busy, 0);
        reset_n = 1'b1;
        repeat (5) @(posedge clk);
        align();

        // 8N1 0xA5 with exact push latency: stop decision falls 156 clocks after the start bit
        rx = 1'b0;
        repeat (N) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) drive_bit(8'hA5 >> i & 8'h01);
        rx = 1'b1;
        repeat (12) @(posedge clk);
        @(negedge clk);
        check("a5_valid_early", m_valid, 0);
        @(posedge clk);
        @(negedge clk);
        check("a5_valid_rise", m_valid, 1);
        check("a5_level", fifo_level, 1);
        repeat (3) @(posedge clk);
        #1;
        pop_expect("a5", 12'h0A5);
        @(negedge clk);
        check("a5_empty", fifo_level, 0);
        align();

        // 7E1, data 0x35 has four ones: p=1 is wrong, p=0 is right
        cfg_data_bits = 3'd7; cfg_parity = 3'd1;
        send_frame(9'h035, 7, 1, 1, 1, 0, 1, 1);
        send_frame(9'h035, 7, 1, 0, 1, 0, 1, 1);
        pop_expect("par_bad", 12'h235);
        pop_expect("par_ok", 12'h035);

        // 3-clock glitch
        cfg_data_bits = 3'd0; cfg_parity = 3'd0;
        align();
        rx = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("glitch_busy", rx_busy, 1);
        repeat (40) @(negedge clk);
        check("glitch_idle", rx_busy, 0);
        check("glitch_level", fifo_level, 0);
        align();

        // 9 data bits, two stop bits, second stop low; then two frames back-to-back
        cfg_data_bits = 3'd1; cfg_stop = 1'b1;
        send_frame(9'h1A3, 9, 0, 0, 1, 1, 0, 1);
        send_frame(9'h0F0, 9, 0, 0, 1, 1, 1, 0);
        send_frame(9'h10F, 9, 0, 0, 1, 1, 1, 2);
        pop_expect("ferr_stop2", 12'h5A3);
        pop_expect("b2b_1", 12'h0F0);
        pop_expect("b2b_2", 12'h10F);

        // Break: line low for 20 bit times
        cfg_data_bits = 3'd0; cfg_stop = 1'b0;
        align();
        rx = 1'b0;
        repeat (20 * N) @(posedge clk);
        @(negedge clk);
        check("brk_level", fifo_level, 1);
        check("brk_word", m_data, 12'hC00);
        check("brk_wait_busy", rx_busy, 1);
        rx = 1'b1;
        repeat (2 * N) @(posedge clk);
        @(negedge clk);
        check("brk_release", rx_busy, 0);
        check("brk_level_hold", fifo_level, 1);
        align();
        send_frame(9'h055, 8, 0, 0, 1, 0, 1, 1);
        pop_expect("brk_pop", 12'hC00);
        pop_expect("after_brk", 12'h055);

        // Overflow of the 4-entry FIFO
        align();
        for (int i = 1; i <= 5; i++) send_frame(9'(i), 8, 0, 0, 1, 0, 1, 1);
        @(negedge clk);
        check("ovf_level", fifo_level, 4);
        check("ovf_set", ovf, 1);
        check("ovf_head", m_data, 12'h001);
        clr_ovf = 1'b1;
        @(posedge clk);
        #1;
        clr_ovf = 1'b0;
        @(negedge clk);
        check("ovf_clr", ovf, 0);
        align();
        fork
            send_frame(9'h006, 8, 0, 0, 1, 0, 1, 1);
            begin
                repeat (156) @(posedge clk);
                #1;
                m_ready = 1'b1;
                @(posedge clk);
                #1;
                m_ready = 1'b0;
            end
        join
        @(negedge clk);
        check("full_pp_level", fifo_level, 4);
        check("full_pp_ovf", ovf, 0);
        check("full_pp_head", m_data, 12'h002);
        align();
        pop_expect("drain2", 12'h002);
        pop_expect("drain3", 12'h003);
        pop_expect("drain4", 12'h004);
        pop_expect("drain6", 12'h006);
        @(negedge clk);
        check("drain_empty", fifo_level, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
